// File: rtl/aes_ctr_pkg.sv
// Shared types and helpers for the AES-256 CTR streaming engine.
package aes_ctr_pkg;

   localparam int BLK_BYTES = 16;

   typedef logic [127:0] block_t;
   typedef logic [255:0] key_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_e;

   // Keep bytes 0..n-1 (byte 0 is the MSB); n = 0 keeps all 16.
   function automatic block_t byte_mask(input logic [3:0] n);
      block_t m;
      m = '1;
      for (int i = 0; i < BLK_BYTES; i++) begin
         if (n != 4'd0 && i >= int'(n)) m[127-8*i -: 8] = 8'h00;
      end
      return m;
   endfunction

endpackage

// File: rtl/aes_ctr_stream_if.sv
// Plaintext-in / ciphertext-out valid/ready streams of aes_ctr_stream.
interface aes_ctr_stream_if;
   import aes_ctr_pkg::*;

   logic   in_valid;
   logic   in_ready;
   block_t in_data;
   logic   out_valid;
   logic   out_ready;
   block_t out_data;
   logic   out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/aes_ctr_ks_fifo.sv
// Keystream prefetch FIFO: synchronous, DEPTH entries of one block each.
module aes_ctr_ks_fifo
   import aes_ctr_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  block_t        din,
   output block_t        dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   block_t        mem_q [DEPTH];
   logic [PW-1:0] wr_q;
   logic [PW-1:0] rd_q;
   logic [CW-1:0] cnt_q;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= inc(wr_q);
         if (pop)  rd_q <= inc(rd_q);
         if (push && !pop)      cnt_q <= cnt_q + 1'b1;
         else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      end
   end

   assign dout  = mem_q[rd_q];
   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;

endmodule

// File: rtl/aes_ctr_stream.sv
// AES-256 CTR streaming engine driving an external block core.
// Optional AES_CTR_WRAP_ERR_EN: flag and stop on counter wrap via err.
module aes_ctr_stream
   import aes_ctr_pkg::*;
#(
   parameter int MAX_BLOCKS = 64,
   parameter int CTR_WIDTH  = 32,
   parameter int KS_DEPTH   = 2,
   parameter int LEN_W      = $clog2(MAX_BLOCKS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  key_t             key,
   input  block_t           iv,
   input  logic [LEN_W-1:0] len_blocks,
   input  logic [3:0]       last_bytes,
   aes_ctr_stream_if.slave  s,
   output logic             busy,
   output logic             done,
   output logic             core_start,
   output block_t           core_blk,
   output key_t             core_key,
   input  logic             core_done,
   input  block_t           core_ct
`ifdef AES_CTR_WRAP_ERR_EN
   ,
   output logic             err
`endif
);

   localparam int CW = $clog2(KS_DEPTH + 1);

   state_e           state_q, state_d;
   key_t             key_q;
   block_t           iv_q;
   logic [LEN_W-1:0] len_q;
   logic [3:0]       lb_q;
   logic [LEN_W-1:0] iss_q;
   logic [LEN_W-1:0] con_q;
   logic             pend_q;
   logic             ov_q;
   logic             ol_q;
   block_t           od_q;
   logic             done_q;
   logic             cs_q;
   block_t           blk_q;

   block_t           ctr_blk;
   block_t           ks_head;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_cnt;
   logic             can_issue;
   logic             issue;
   logic             halt;
   logic             in_ready;
   logic             fire;
   logic             is_last;
   logic             drained;
   logic             push;

   always_comb begin
      ctr_blk = iv_q;
      ctr_blk[CTR_WIDTH-1:0] = iv_q[CTR_WIDTH-1:0] + CTR_WIDTH'(iss_q);
   end

   assign can_issue = (state_q == RUN) && !pend_q && !halt &&
                      (iss_q < len_q) &&
                      (int'(fifo_cnt) + int'(pend_q) < KS_DEPTH);

`ifdef AES_CTR_WRAP_ERR_EN
   logic err_q;
   logic wrap;
   logic set_err;

   // A wrapped low word would reuse a counter block already consumed.
   assign wrap    = (iss_q != '0) && (ctr_blk[CTR_WIDTH-1:0] == '0);
   assign issue   = can_issue && !wrap;
   assign set_err = can_issue && wrap;
   assign halt    = err_q;
   assign err     = err_q;

   always_ff @(posedge clk) begin
      if (rst)                          err_q <= 1'b0;
      else if (state_q == IDLE && start) err_q <= 1'b0;
      else if (set_err)                 err_q <= 1'b1;
   end
`else
   assign issue = can_issue;
   assign halt  = 1'b0;
`endif

   assign in_ready = (state_q == RUN) && !fifo_empty &&
                     (con_q < len_q) && (!ov_q || s.out_ready);
   assign fire     = s.in_valid && in_ready;
   assign is_last  = (con_q == len_q - LEN_W'(1));
   assign push     = core_done && (state_q == RUN) && !fifo_full;
   assign drained  = !ov_q && ((con_q == len_q) ||
                     (halt && !pend_q && fifo_empty));

   aes_ctr_ks_fifo #(.DEPTH(KS_DEPTH), .CW(CW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (fire),
      .din   (core_ct),
      .dout  (ks_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = (len_blocks == '0) ? FIN : RUN;
         RUN:     if (drained) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         key_q   <= '0;
         iv_q    <= '0;
         len_q   <= '0;
         lb_q    <= '0;
         iss_q   <= '0;
         con_q   <= '0;
         pend_q  <= 1'b0;
         ov_q    <= 1'b0;
         ol_q    <= 1'b0;
         od_q    <= '0;
         done_q  <= 1'b0;
         cs_q    <= 1'b0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == FIN);
         cs_q    <= issue;
         if (state_q == IDLE && start) begin
            key_q  <= key;
            iv_q   <= iv;
            len_q  <= len_blocks;
            lb_q   <= last_bytes;
            iss_q  <= '0;
            con_q  <= '0;
            pend_q <= 1'b0;
         end
         if (issue) begin
            blk_q  <= ctr_blk;
            iss_q  <= iss_q + LEN_W'(1);
            pend_q <= 1'b1;
         end else if (core_done) begin
            pend_q <= 1'b0;
         end
         if (fire) begin
            od_q  <= (s.in_data ^ ks_head) &
                     (is_last ? byte_mask(lb_q) : '1);
            ol_q  <= is_last;
            ov_q  <= 1'b1;
            con_q <= con_q + LEN_W'(1);
         end else if (ov_q && s.out_ready) begin
            ov_q <= 1'b0;
            ol_q <= 1'b0;
         end
      end
   end

   assign s.in_ready  = in_ready;
   assign s.out_valid = ov_q;
   assign s.out_data  = od_q;
   assign s.out_last  = ol_q;
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign core_start  = cs_q;
   assign core_blk    = blk_q;
   assign core_key    = key_q;

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Self-checking bench for aes_ctr_stream with a behavioural AES core stand-in.
`timescale 1ns/1ps
module tb_aes_ctr_stream;
   import aes_ctr_pkg::*;

   localparam int LEN_W    = 7;
   localparam int KS_DEPTH = 2;
   localparam int NB       = 4;
   localparam int NV       = 6;

   localparam key_t   NK   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam block_t NIV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam block_t NIV1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
   localparam block_t NPT0 = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam block_t NPT1 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam block_t NCT0 = 128'h601ec313775789a5b7a7f504bbf3d228;
   localparam block_t NCT1 = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
   localparam block_t NPRT = 128'h601ec313770000000000000000000000;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   key_t             key;
   block_t           iv;
   logic [LEN_W-1:0] len_blocks;
   logic [3:0]       last_bytes;
   logic             busy;
   logic             done;
   logic             core_start;
   block_t           core_blk;
   key_t             core_key;
   logic             core_done;
   block_t           core_ct;
`ifdef AES_CTR_WRAP_ERR_EN
   logic             err;
`endif

   aes_ctr_stream_if sif ();

   aes_ctr_stream #(
      .MAX_BLOCKS (64),
      .CTR_WIDTH  (32),
      .KS_DEPTH   (KS_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key        (key),
      .iv         (iv),
      .len_blocks (len_blocks),
      .last_bytes (last_bytes),
      .s          (sif),
      .busy       (busy),
      .done       (done),
      .core_start (core_start),
      .core_blk   (core_blk),
      .core_key   (core_key),
      .core_done  (core_done),
      .core_ct    (core_ct)
`ifdef AES_CTR_WRAP_ERR_EN
      ,
      .err        (err)
`endif
   );

   always #5 clk = ~clk;

   // Known-answer entries for the NIST blocks, a keyed mix elsewhere.
   function automatic block_t ks_fn(input key_t k, input block_t b);
      if (k == NK && b == NIV)  return NCT0 ^ NPT0;
      if (k == NK && b == NIV1) return NCT1 ^ NPT1;
      return {b[63:0], b[127:64]} ^ k[255:128] ^ k[127:0] ^
             128'h0123456789abcdeffedcba9876543210;
   endfunction

   function automatic block_t mask_fn(input int n);
      block_t ones;
      ones = '1;
      if (n == 0) return ones;
      return ~(ones >> (8 * n));
   endfunction

   // AES core stand-in: fixed latency, one request at a time.
   block_t      blk_log [$];
   int unsigned lat_q;
   block_t      mblk;
   key_t        mkey;
   always @(posedge clk) begin
      core_done <= 1'b0;
      if (rst) begin
         lat_q   <= 0;
         core_ct <= '0;
      end else if (core_start) begin
         lat_q <= 3;
         mblk  <= core_blk;
         mkey  <= core_key;
         blk_log.push_back(core_blk);
      end else if (lat_q == 1) begin
         core_done <= 1'b1;
         core_ct   <= ks_fn(mkey, mblk);
         lat_q     <= 0;
      end else if (lat_q != 0) begin
         lat_q <= lat_q - 1;
      end
   end

   typedef struct {
      key_t   k;
      block_t iv;
      int     len;
      int     lb;
      block_t pt [NB];
      block_t ct [NB];
   } vec_t;

   typedef struct packed {
      logic   last;
      block_t d;
   } exp_t;

   vec_t vt [NV];
   exp_t sb [$];
   int   checks = 0;
   int   errors = 0;
   int   blk_base;

   task automatic chk_blk(input string nm, input block_t act, input block_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string t);
      chk_int({t, "_out_valid"}, int'(sif.out_valid), 0);
      chk_int({t, "_out_last"}, int'(sif.out_last), 0);
      chk_int({t, "_in_ready"}, int'(sif.in_ready), 0);
      chk_int({t, "_busy"}, int'(busy), 0);
      chk_int({t, "_done"}, int'(done), 0);
      chk_int({t, "_core_start"}, int'(core_start), 0);
      chk_blk({t, "_out_data"}, sif.out_data, '0);
      chk_blk({t, "_core_blk"}, core_blk, '0);
      chk_int({t, "_core_key"}, int'(core_key != '0), 0);
   endtask

   task automatic mk_vec(input int v, input int len, input int lb, input bit wrap);
      vec_t t;
      block_t c;
      for (int w = 0; w < 8; w++) t.k[w*32 +: 32] = $urandom();
      for (int w = 0; w < 4; w++) t.iv[w*32 +: 32] = $urandom();
      if (wrap) t.iv[31:0] = 32'hffffffff;
      t.len = len;
      t.lb  = lb;
      for (int i = 0; i < NB; i++) begin
         for (int w = 0; w < 4; w++) t.pt[i][w*32 +: 32] = $urandom();
         c = t.iv;
         c[31:0] = t.iv[31:0] + 32'(i);
         t.ct[i] = t.pt[i] ^ ks_fn(t.k, c);
         if (i == len - 1) t.ct[i] = t.ct[i] & mask_fn(lb);
      end
      vt[v] = t;
   endtask

   task automatic do_start(input int v, input int len);
      key        = vt[v].k;
      iv         = vt[v].iv;
      len_blocks = LEN_W'(len);
      last_bytes = 4'(vt[v].lb);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_vec(input int v, input int st_at, input int st_len);
      int     beat, got, cyc, dn, iss, len;
      logic   acc, hold, hl;
      block_t hd;
      exp_t   e;
      beat = 0; got = 0; cyc = 0; dn = 0; iss = 0;
      hold = 1'b0; hl = 1'b0; hd = '0;
      len = vt[v].len;
      sb.delete();
      blk_base = blk_log.size();
      do_start(v, len);
      while ((got < len || dn == 0) && cyc < 400) begin
         sif.in_valid  = (beat < len);
         sif.in_data   = vt[v].pt[(beat < NB) ? beat : 0];
         sif.out_ready = !(cyc >= st_at && cyc < st_at + st_len);
         @(negedge clk);
         if (core_start) iss++;
         if (done) dn++;
         acc = sif.in_valid && sif.in_ready;
         if (acc) begin
            e.last = (beat == len - 1);
            e.d    = vt[v].ct[beat];
            sb.push_back(e);
         end
         if (hold) begin
            chk_blk("hold_data", sif.out_data, hd);
            chk_int("hold_last", int'(sif.out_last), int'(hl));
         end
         hold = sif.out_valid && !sif.out_ready;
         if (hold) begin
            chk_int("hold_in_ready", int'(sif.in_ready), 0);
            hd = sif.out_data;
            hl = sif.out_last;
         end
         chk_int("ks_window", int'(iss - beat <= KS_DEPTH), 1);
         if (sif.out_valid && sif.out_ready) begin
            if (sb.size() == 0) begin
               chk_int("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               chk_blk($sformatf("v%0d_beat%0d_data", v, got), sif.out_data, e.d);
               chk_int($sformatf("v%0d_beat%0d_last", v, got), int'(sif.out_last), int'(e.last));
            end
            got++;
         end
         @(posedge clk);
         #1;
         if (acc) beat++;
         cyc++;
      end
      sif.in_valid  = 1'b0;
      sif.out_ready = 1'b1;
      chk_int($sformatf("v%0d_timeout", v), int'(cyc < 400), 1);
      chk_int($sformatf("v%0d_beats", v), got, len);
      chk_int($sformatf("v%0d_issued", v), iss, len);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) dn++;
         @(posedge clk);
         #1;
      end
      chk_int($sformatf("v%0d_done_count", v), dn, 1);
      chk_int($sformatf("v%0d_busy_end", v), int'(busy), 0);
   endtask

   initial begin
      int acc_n, cyc, iss, dn, got;
      logic acc;

      vt[0].k = NK; vt[0].iv = NIV; vt[0].len = 2; vt[0].lb = 0;
      vt[0].pt[0] = NPT0; vt[0].pt[1] = NPT1;
      vt[0].ct[0] = NCT0; vt[0].ct[1] = NCT1;
      vt[1] = vt[0];
      vt[1].len = 1; vt[1].lb = 5; vt[1].ct[0] = NPRT;
      mk_vec(2, 4, 0, 1'b0);
      mk_vec(3, 3, 15, 1'b0);
      mk_vec(4, 2, 0, 1'b1);
      mk_vec(5, 4, 7, 1'b0);

      rst = 1'b1; start = 1'b0; key = '0; iv = '0;
      len_blocks = '0; last_bytes = '0;
      sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int v = 0; v < 4; v++) run_vec(v, (v == 2) ? 8 : 1000, 10);

`ifdef AES_CTR_WRAP_ERR_EN
      blk_base = blk_log.size();
      acc_n = 0; cyc = 0; iss = 0; dn = 0; got = 0;
      do_start(4, 2);
      while (dn == 0 && cyc < 200) begin
         sif.in_valid  = (acc_n < 2);
         sif.in_data   = vt[4].pt[(acc_n < 2) ? acc_n : 0];
         sif.out_ready = 1'b1;
         @(negedge clk);
         if (core_start) iss++;
         if (done) dn++;
         acc = sif.in_valid && sif.in_ready;
         if (sif.out_valid) begin
            chk_blk("wrap_err_data", sif.out_data, vt[4].ct[0]);
            got++;
         end
         @(posedge clk);
         #1;
         if (acc) acc_n++;
         cyc++;
      end
      sif.in_valid = 1'b0;
      chk_int("wrap_err_timeout", int'(cyc < 200), 1);
      chk_int("wrap_err_starts", iss, 1);
      chk_int("wrap_err_accepted", acc_n, 1);
      chk_int("wrap_err_outputs", got, 1);
      chk_int("wrap_err_flag", int'(err), 1);
      chk_blk("wrap_err_blk0", blk_log[blk_base], vt[4].iv);
`else
      run_vec(4, 1000, 10);
      chk_blk("wrap_blk0", blk_log[blk_base], vt[4].iv);
      chk_blk("wrap_blk1", blk_log[blk_base+1], {vt[4].iv[127:32], 32'h0});
`endif

      // len_blocks 0: straight to FIN, done two edges after start.
      iss = 0; dn = 0; got = 0;
      do_start(0, 0);
      chk_int("len0_done_e1", int'(done), 0);
      chk_int("len0_busy_e1", int'(busy), 1);
      @(posedge clk);
      #1;
      chk_int("len0_done_e2", int'(done), 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (core_start) iss++;
         if (sif.out_valid) got++;
         if (done) dn++;
         @(posedge clk);
         #1;
      end
      chk_int("len0_done_count", dn, 1);
      chk_int("len0_core_start", iss, 0);
      chk_int("len0_out_valid", got, 0);

      // Abort a 4-block run after its first accepted beat.
      acc_n = 0; cyc = 0;
      do_start(2, 4);
      while (acc_n < 1 && cyc < 100) begin
         sif.in_valid  = 1'b1;
         sif.in_data   = vt[2].pt[0];
         sif.out_ready = 1'b1;
         @(negedge clk);
         acc = sif.in_valid && sif.in_ready;
         @(posedge clk);
         #1;
         if (acc) acc_n++;
         cyc++;
      end
      chk_int("abort_timeout", int'(cyc < 100), 1);
      rst = 1'b1;
      sif.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk_reset("abort");
      rst = 1'b0;
      dn = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done) dn++;
         @(posedge clk);
         #1;
      end
      chk_int("abort_no_done", dn, 0);

      run_vec(5, 1000, 10);
      chk_blk("restart_blk0", blk_log[blk_base], vt[5].iv);
`ifdef AES_CTR_WRAP_ERR_EN
      chk_int("restart_err_clear", int'(err), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_ctr_stream.md
Name: aes_ctr_stream

Overview:
- Parametrised AES-256 CTR-mode streaming engine; successor to the fixed 8-block, non-handshaked CTR encryptor.
- Takes key, IV and message length in blocks. Drives an external AES-256 block core to generate keystream, prefetching up to KS_DEPTH blocks ahead.
- XORs keystream with a valid/ready input stream and returns ciphertext on a valid/ready output stream.
- Supports a partial final block, masked to whole bytes.
- Sits between the message buffer and the AES core (encryptiontop, wrapped with start/done).

Parameters:
- MAX_BLOCKS, 64, largest message length in 128-bit blocks; LEN_W = clog2(MAX_BLOCKS+1).
- CTR_WIDTH, 32, low IV bits that increment per block; upper 128-CTR_WIDTH bits are constant.
- KS_DEPTH, 2, keystream prefetch FIFO depth; legal range 1..8.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  load key/iv/len; honoured only in IDLE.
- key  in  256  AES-256 key, sampled on start.
- iv  in  128  initial counter block, sampled on start.
- len_blocks  in  LEN_W  number of blocks, sampled on start; 0 is legal.
- last_bytes  in  4  valid bytes in final block; 0 means 16.
- in_valid  in  1  plaintext beat valid.
- in_ready  out  1  engine accepts a plaintext beat.
- in_data  in  128  plaintext block; byte 0 is bits [127:120].
- out_valid  out  1  ciphertext beat valid.
- out_ready  in  1  sink accepts the beat.
- out_data  out  128  ciphertext block.
- out_last  out  1  marks the final beat.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when the run completes.
- core_start  out  1  one-cycle request to the AES core.
- core_blk  out  128  counter block for the core, held until core_done.
- core_key  out  256  latched key.
- core_done  in  1  core result valid, one cycle.
- core_ct  in  128  encrypted counter block.

Behaviour:
- Reset values:
  - out_valid, out_last, in_ready, busy, done and core_start are 0.
  - out_data, core_blk and core_key are 0.
  - FIFO is empty; FSM is in IDLE.
- FSM states:
  - IDLE: start moves to RUN, or to FIN if len_blocks is 0. Key, iv and len are latched; issue and consume counters are cleared.
  - RUN: keystream generation and data path run concurrently. When consumed equals len and the output register has drained, move to FIN.
  - FIN: done=1 for one cycle, then return to IDLE.
  - start outside IDLE is ignored.
- Keystream generation (in RUN):
  - core_start pulses when there is no outstanding core request, issued < len, and FIFO occupancy plus outstanding count is below KS_DEPTH.
  - core_blk = {iv_hi, (iv_lo + issued) mod 2^CTR_WIDTH}; issued increments on core_start.
  - core_done pushes core_ct into the FIFO. At most one request is outstanding.
- Data path:
  - in_ready = RUN && FIFO non-empty && consumed < len && (!out_valid || out_ready).
  - On in_valid && in_ready:
    - out_data <= in_data ^ fifo_head and out_valid <= 1 on the next edge, so latency is 1 cycle.
    - The FIFO pops; consumed increments.
  - out_last = 1 when the beat is block len-1.
  - Final block with last_bytes = n, n in 1..15: bytes n..15 of out_data are forced to 0.
- Output hold: while out_valid && !out_ready, out_data and out_last are stable and in_ready is 0.
- Simultaneous FIFO push and pop in the same cycle is legal; occupancy is unchanged.
- Counter wrap: iv_lo at all-ones wraps to 0 without touching iv_hi.
- rst at any time aborts the run: all state returns to reset values and no done pulse is generated. The core is reset by the same rst.

Optional Feature:
- Macro: AES_CTR_WRAP_ERR_EN.
- When defined, adds an output `err` (1 bit, reset 0).
  - If an issue would wrap iv_lo within a run, the engine sets err, issues no further requests, drains already-buffered blocks, then enters FIN.
  - err clears on the next accepted start.
- When undefined, there is no err port and the counter wraps silently.

Decomposition:
- Package aes_ctr_pkg holds:
  - block_t (128 bits) and key_t (256 bits).
  - FSM state enum {IDLE, RUN, FIN}.
  - byte_mask function (last_bytes to 128-bit mask).
  - Constant BLK_BYTES=16.
- Sub-module aes_ctr_ks_fifo: synchronous FIFO, parameter DEPTH, with push, pop, full, empty and count.

Test Plan:
- NIST SP800-38A F.5.5:
  - key 603deb10...0914dff4, iv f0f1...feff, len 2, last_bytes 0.
  - Plaintext 6bc1bee22e409f96e93d7e117393172a, ae2d8a571e03ac9c9eb76fac45af8e51.
  - Expect ciphertext 601ec313775789a5b7a7f504bbf3d228, f443e3ca4d62b59aca84e990cacaf5c5; out_last on beat 2; one done pulse.
- Partial block: same vector, len 1, last_bytes 5 -> out_data 601ec31377 followed by 22 zero nibbles.
- Wrap: iv low 32 bits = ffffffff, len 2 -> core_blk low word ffffffff then 00000000, upper 96 bits unchanged.
  - With AES_CTR_WRAP_ERR_EN: err=1 and only one core_start.
- Backpressure: out_ready held low 10 cycles mid-stream -> out_data stable, in_ready=0, at most KS_DEPTH outstanding-plus-buffered keystream blocks, no lost or duplicated beats.
- len_blocks 0: start -> done exactly 2 cycles later, no core_start, no out_valid.
- rst asserted during RUN after 1 of 4 blocks -> all outputs at reset values next cycle; a following start with a new key runs cleanly from block 0.
